// File: rtl/cmp_pkg.sv
// Shared types and defaults for the shared-comparator arbiter.
// The optional CMP_SIGNED_EN macro (see cmp_core) selects a signed compare.
package cmp_pkg;

  localparam int CMP_N_DEF    = 32;
  localparam int CMP_REQS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  // One-hot less / greater / equal result.
  typedef struct packed {
    logic L;
    logic G;
    logic E;
  } cmp_res_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational N-bit magnitude comparator, instantiated once and shared.
// Define CMP_SIGNED_EN for a two's-complement compare; unsigned otherwise.
module cmp_core #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         L,
  output logic         G,
  output logic         E
);

`ifdef CMP_SIGNED_EN
  assign L = $signed(a) < $signed(b);
  assign G = $signed(a) > $signed(b);
`else
  assign L = a < b;
  assign G = a > b;
`endif
  // Equality is bitwise regardless of signedness.
  assign E = (a == b);

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter that time-shares one comparator among REQS clients.
// IDLE grants and captures operands, CMP registers the result, RESP holds it
// until the consumer takes it. CMP_SIGNED_EN only changes cmp_core.
module cmp_share_arb
  import cmp_pkg::*;
#(
  parameter int N    = CMP_N_DEF,
  parameter int REQS = CMP_REQS_DEF,
  parameter int IDW  = $clog2(REQS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REQS-1:0]     req_valid,
  output logic [REQS-1:0]     req_ready,
  input  logic [REQS*N-1:0]   req_a,
  input  logic [REQS*N-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_L,
  output logic                rsp_G,
  output logic                rsp_E
);

  typedef struct packed {
    logic           found;
    logic [IDW-1:0] idx;
  } pick_t;

  // First valid requester at or after ptr, wrapping modulo REQS.
  function automatic pick_t rr_pick(input logic [REQS-1:0] v,
                                    input logic [IDW-1:0]  ptr);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < REQS; k++) begin
      j = (int'(ptr) + k) % REQS;
      if (!p.found && v[j]) begin
        p.found = 1'b1;
        p.idx   = IDW'(j);
      end
    end
    return p;
  endfunction

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [N-1:0]    op_a_q, op_a_d;
  logic [N-1:0]    op_b_q, op_b_d;
  cmp_res_t        rsp_q, rsp_d;
  cmp_res_t        core_res;
  pick_t           pick;

  logic [N-1:0]    a_arr [REQS];
  logic [N-1:0]    b_arr [REQS];

  // Unpack the flat operand buses so the grant index selects a whole lane.
  for (genvar i = 0; i < REQS; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*N +: N];
    assign b_arr[i] = req_b[i*N +: N];
  end

  cmp_core #(.N(N)) u_core (
    .a (op_a_q),
    .b (op_b_q),
    .L (core_res.L),
    .G (core_res.G),
    .E (core_res.E)
  );

  // Next-state, grant and datapath capture; req_ready never looks at rsp_ready.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rsp_d     = rsp_q;
    req_ready = '0;
    pick      = rr_pick(req_valid, rr_ptr_q);
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          req_ready[pick.idx] = 1'b1;
          op_a_d  = a_arr[pick.idx];
          op_b_d  = b_arr[pick.idx];
          id_d    = pick.idx;
          state_d = CMP;
        end
      end
      CMP: begin
        rsp_d   = core_res;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          // Pointer moves past the winner only once its result is consumed.
          rr_ptr_d = (id_q == IDW'(REQS-1)) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      rsp_q    <= rsp_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_L     = rsp_q.L;
  assign rsp_G     = rsp_q.G;
  assign rsp_E     = rsp_q.E;

endmodule

// File: tb/tb_cmp_share_arb.sv
// Self-checking bench for cmp_share_arb: vector table, directed corner
// sequences, then random traffic against a transaction-level model.
module tb_cmp_share_arb;
  localparam int N    = 32;
  localparam int REQS = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [REQS-1:0]   req_valid;
  logic [REQS-1:0]   req_ready;
  logic [REQS*N-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_L, rsp_G, rsp_E;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmp_share_arb #(.N(N), .REQS(REQS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_L     (rsp_L),
    .rsp_G     (rsp_G),
    .rsp_E     (rsp_E)
  );

  typedef struct {
    int          lane;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]  lge;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  // Reference compare, {L,G,E}.
  function automatic logic [2:0] ref_cmp(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef CMP_SIGNED_EN
    return {$signed(a) < $signed(b), $signed(a) > $signed(b), a == b};
`else
    return {a < b, a > b, a == b};
`endif
  endfunction

  function automatic int oh_idx(input logic [REQS-1:0] v);
    int r;
    r = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < REQS; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    nxt(); nxt();
    rst = 1'b0;
  endtask

  // One isolated request: accept, latency and result fields.
  task automatic run_one(input string nm, input int lane, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [2:0] lge);
    bit got;
    int lat;
    got = 0;
    req_valid = '0; req_valid[lane] = 1'b1; set_op(lane, a, b);
    for (int c = 0; c < 8 && !got; c++) begin
      #1;
      if (req_ready != '0) begin
        got = 1;
        chk({nm, "_ready"}, req_ready, 4'b1 << lane);
      end
      nxt();
    end
    chk({nm, "_accepted"}, got, 1);
    req_valid = '0;
    got = 0; lat = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      #1;
      lat++;
      if (rsp_valid) begin
        got = 1;
        chk({nm, "_latency"}, lat, 2);
        chk({nm, "_id"}, rsp_id, lane);
        chk({nm, "_lge"}, {rsp_L, rsp_G, rsp_E}, lge);
      end
      nxt();
    end
    chk({nm, "_rsp_seen"}, got, 1);
  endtask

  vec_t vt [8];

  // Random-phase model state.
  bit            pend [REQS];
  logic [N-1:0]  ma [REQS];
  logic [N-1:0]  mb [REQS];
  bit            busy;
  int            age, cur_id, ptr, g;
  logic [2:0]    cur_res;
  logic [REQS-1:0] exp_rdy;

  function automatic logic [N-1:0] rnd_op(input int sel);
    logic [N-1:0] ext [4];
    ext[0] = '0; ext[1] = '1; ext[2] = 32'h8000_0000; ext[3] = 32'h7FFF_FFFF;
    case (sel)
      0: return ext[$urandom_range(0, 3)];
      1: return N'($urandom_range(0, 7));
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    req_a = '0; req_b = '0; req_valid = '0; rsp_ready = 1'b1; rst = 1'b1;

    // ---------------- reset state
    reset_dut();
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_lge", {rsp_L, rsp_G, rsp_E}, 3'b000);
    chk("rst_id", rsp_id, 0);
    chk("rst_req_ready", req_ready, 0);
    nxt();

    // ---------------- single request, lane 2
    req_valid = 4'b0100; set_op(2, 100, 7);
    #1; chk("single_ready_T", req_ready, 4'b0100);
    nxt(); req_valid = '0;
    #1; chk("single_T1_valid", rsp_valid, 0);
    chk("single_T1_ready", req_ready, 0);
    nxt();
    #1; chk("single_T2_valid", rsp_valid, 1);
    chk("single_T2_id", rsp_id, 2);
    chk("single_T2_lge", {rsp_L, rsp_G, rsp_E}, 3'b010);
    nxt();

    // ---------------- vector table
    vt[0] = '{0, 32'd100, 32'd7, 3'b010};
    vt[1] = '{1, 32'h8000_0000, 32'h8000_0000, 3'b001};
    vt[2] = '{2, 32'd5, 32'd6, 3'b100};
    vt[3] = '{3, 32'd0, 32'd0, 3'b001};
    vt[4] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001};
`ifdef CMP_SIGNED_EN
    vt[5] = '{1, 32'hFFFF_FFFF, 32'd0, 3'b100};
    vt[6] = '{2, 32'hFFFF_FFFF, 32'd1, 3'b100};
    vt[7] = '{3, 32'h7FFF_FFFF, 32'h8000_0000, 3'b010};
`else
    vt[5] = '{1, 32'hFFFF_FFFF, 32'd0, 3'b010};
    vt[6] = '{2, 32'hFFFF_FFFF, 32'd1, 3'b010};
    vt[7] = '{3, 32'h7FFF_FFFF, 32'h8000_0000, 3'b100};
`endif
    for (int k = 0; k < 8; k++)
      run_one($sformatf("vec%0d", k), vt[k].lane, vt[k].a, vt[k].b, vt[k].lge);

    // ---------------- all four valid from reset
    begin
      int order [5];
      int when [5];
      int ng;
      reset_dut();
      for (int i = 0; i < REQS; i++) set_op(i, i, 2);
      req_valid = 4'b1111;
      ng = 0;
      for (int c = 0; c < 40 && ng < 5; c++) begin
        #1;
        if (req_ready != '0) begin
          order[ng] = oh_idx(req_ready);
          when[ng] = c;
          ng++;
        end
        nxt();
      end
      req_valid = '0;
      chk("all4_grants", ng, 5);
      for (int k = 0; k < ng; k++) begin
        chk($sformatf("all4_order%0d", k), order[k], k % REQS);
        if (k > 0) chk($sformatf("all4_gap%0d", k), when[k] - when[k-1], 3);
      end
      chk("all4_first_cycle", when[0], 0);
      repeat (3) nxt();
    end

    // ---------------- backpressure
    reset_dut();
    rsp_ready = 1'b0;
    set_op(0, 3, 9); req_valid = 4'b0001;
    #1; chk("bp_accept0", req_ready, 4'b0001);
    nxt();
    req_valid = 4'b0010; set_op(1, 50, 50);
    #1; chk("bp_cmp_ready", req_ready, 0);
    nxt();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_stall_valid", rsp_valid, 1);
      chk("bp_stall_id", rsp_id, 0);
      chk("bp_stall_lge", {rsp_L, rsp_G, rsp_E}, 3'b100);
      chk("bp_stall_ready", req_ready, 0);
      nxt();
    end
    rsp_ready = 1'b1;
    #1; chk("bp_release_valid", rsp_valid, 1);
    chk("bp_release_ready", req_ready, 0);
    nxt();
    #1; chk("bp_grant1", req_ready, 4'b0010);
    nxt(); req_valid = '0;
    nxt();
    #1; chk("bp_rsp1_lge", {rsp_valid, rsp_id, rsp_L, rsp_G, rsp_E}, {1'b1, 2'd1, 3'b001});
    nxt();

    // ---------------- reset mid-operation
    reset_dut();
    set_op(2, 1, 1); req_valid = 4'b0100;
    #1; chk("mid_accept", req_ready, 4'b0100);
    nxt();
    req_valid = '0; rst = 1'b1;
    nxt();
    rst = 1'b0;
    #1;
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_outs", {rsp_id, rsp_L, rsp_G, rsp_E}, 0);
    set_op(3, 1, 2); set_op(0, 2, 1); req_valid = 4'b1001;
    #1; chk("mid_grant0_first", req_ready, 4'b0001);
    nxt(); req_valid = 4'b1000;
    nxt();
    #1; chk("mid_no_rsp_lane2", {rsp_valid, rsp_id}, {1'b1, 2'd0});
    nxt();
    #1; chk("mid_grant3_next", req_ready, 4'b1000);
    nxt(); req_valid = '0;
    repeat (3) nxt();

    // ---------------- fairness: lane 0 hogging, lane 3 pulses once
    begin
      int ng;
      bit got3;
      reset_dut();
      set_op(0, 7, 7); req_valid = 4'b0001;
      #1; chk("fair_first0", req_ready, 4'b0001);
      nxt();
      set_op(3, 0, 1); req_valid = 4'b1001;
      ng = 0; got3 = 0;
      for (int c = 0; c < 20 && !got3 && ng < 2; c++) begin
        #1;
        if (req_ready != '0) begin
          ng++;
          if (req_ready[3]) got3 = 1;
        end
        nxt();
        if (got3) req_valid[3] = 1'b0;
      end
      chk("fair_lane3_granted", got3, 1);
      req_valid = '0;
      repeat (4) nxt();
    end

    // ---------------- random traffic vs transaction model
    reset_dut();
    for (int i = 0; i < REQS; i++) pend[i] = 0;
    busy = 0; age = 0; cur_id = 0; ptr = 0; cur_res = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < REQS; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          int s;
          s = $urandom_range(0, 3);
          pend[i] = 1;
          ma[i] = rnd_op(s);
          mb[i] = (s == 3) ? ma[i] : rnd_op($urandom_range(0, 2));
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 0;  // legal withdrawal before grant
        end
        req_valid[i] = pend[i];
        set_op(i, ma[i], mb[i]);
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      // Expected grant: only when no transaction outstanding.
      g = -1;
      if (!busy)
        for (int k = 0; k < REQS; k++)
          if (g < 0 && pend[(ptr + k) % REQS]) g = (ptr + k) % REQS;
      exp_rdy = (g >= 0) ? (4'b1 << g) : 4'b0;
      #1;
      chk("rnd_req_ready", req_ready, exp_rdy);
      chk("rnd_rsp_valid", rsp_valid, busy && age >= 2);
      if (busy && age >= 2)
        chk("rnd_rsp", {rsp_id, rsp_L, rsp_G, rsp_E}, {cur_id[IDW-1:0], cur_res});
      if (busy) begin
        if (age >= 2 && rsp_ready) begin
          busy = 0;
          ptr = (cur_id + 1) % REQS;
        end else age++;
      end else if (g >= 0) begin
        busy = 1; age = 1; cur_id = g;
        cur_res = ref_cmp(ma[g], mb[g]);
        pend[g] = 0;
      end
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "timeout");
  end

endmodule
